// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ packet sources.
// Define UART_ARB_GAP_EN to insert GAP_CYCLES idle clocks after every packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int Word_len   = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ*Word_len-1:0]                   req_data,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ-1:0]                            req_last,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic [Word_len-1:0]                           tx_data,
  output logic                                          tx_data_valid,
  output logic                                          tx_data_last,
  input  logic                                          tx_data_ready,
  output logic                                          grant_valid,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef UART_ARB_GAP_EN
  typedef enum logic [1:0] {ARB = 2'd0, XFER = 2'd1, GAP = 2'd2} state_t;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GCW-1:0] gap_cnt_reg, gap_cnt_next;
`else
  typedef enum logic {ARB = 1'b0, XFER = 1'b1} state_t;
`endif

  state_t        state_reg, state_next;
  logic [GW-1:0] ptr_reg, ptr_next;
  logic [GW-1:0] grant_id_reg, grant_id_next;

  logic [Word_len-1:0] word [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign word[gi] = req_data[gi*Word_len +: Word_len];
    end
  endgenerate

  // Rotate the request vector so bit 0 is the requester at ptr; lowest set bit wins.
  logic [NUM_REQ-1:0] valid_rot;
  logic               pick_found;
  logic [GW:0]        pick_off;
  logic [GW:0]        pick_sum;
  logic [GW-1:0]      pick_id;

  assign valid_rot = NUM_REQ'({req_valid, req_valid} >> ptr_reg);

  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (valid_rot[j]) begin
        pick_found = 1'b1;
        pick_off   = (GW+1)'(j);
      end
    end
    pick_sum = {1'b0, ptr_reg} + pick_off;
    if (pick_sum >= (GW+1)'(NUM_REQ)) begin
      pick_sum = pick_sum - (GW+1)'(NUM_REQ);
    end
    pick_id = pick_sum[GW-1:0];
  end

  logic                gnt_valid;
  logic                gnt_last;
  logic [Word_len-1:0] gnt_data;
  logic                last_xfer;
  logic [GW-1:0]       ptr_after;

  assign gnt_valid = req_valid[grant_id_reg];
  assign gnt_last  = req_last[grant_id_reg];
  assign gnt_data  = word[grant_id_reg];
  assign last_xfer = (state_reg == XFER) && gnt_valid && gnt_last && tx_data_ready;
  assign ptr_after = (grant_id_reg == GW'(NUM_REQ - 1)) ? '0 : grant_id_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ARB;
      ptr_reg      <= '0;
      grant_id_reg <= '0;
`ifdef UART_ARB_GAP_EN
      gap_cnt_reg  <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      grant_id_reg <= grant_id_next;
`ifdef UART_ARB_GAP_EN
      gap_cnt_reg  <= gap_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    grant_id_next = grant_id_reg;
`ifdef UART_ARB_GAP_EN
    gap_cnt_next  = gap_cnt_reg;
`endif
    case (state_reg)
      ARB: begin
        if (pick_found) begin
          state_next    = XFER;
          grant_id_next = pick_id;
        end
      end
      XFER: begin
        // Ownership is released only by an accepted last word.
        if (last_xfer) begin
          ptr_next     = ptr_after;
`ifdef UART_ARB_GAP_EN
          state_next   = GAP;
          gap_cnt_next = '0;
`else
          state_next   = ARB;
`endif
        end
      end
`ifdef UART_ARB_GAP_EN
      GAP: begin
        if (gap_cnt_reg == GCW'(GAP_CYCLES - 1)) begin
          state_next = ARB;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
`endif
      default: state_next = ARB;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    tx_data       = '0;
    tx_data_valid = 1'b0;
    tx_data_last  = 1'b0;
    grant_valid   = 1'b0;
    if (state_reg == XFER) begin
      tx_data                 = gnt_data;
      tx_data_valid           = gnt_valid;
      tx_data_last            = gnt_last;
      grant_valid             = 1'b1;
      req_ready[grant_id_reg] = tx_data_ready;
    end
  end

  assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed requesters, packet-level model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;
`ifdef UART_ARB_GAP_EN
  localparam int GAPC = 16;
`else
  localparam int GAPC = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [W-1:0]    tx_data;
  logic            tx_data_valid;
  logic            tx_data_last;
  logic            tx_data_ready;
  logic            grant_valid;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .Word_len(W), .GAP_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_data_last(tx_data_last),
    .tx_data_ready(tx_data_ready), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {int id; int data; bit last; int cyc;} ent_t;
  ent_t log_q[$];

  logic [W-1:0] sq_d [NR][$];
  bit           sq_l [NR][$];
  bit           hold [NR];
  bit           rdy_ctl = 1'b1;
  bit           rst_ctl = 1'b1;
  bit           cmp_en  = 1'b0;

  // Model: who owns the transmitter (-1 = nobody), round-robin start, idle clocks left.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_gid   = 0;
  int m_gap   = 0;
  int cyc     = 0;

  logic [NR-1:0]   drv_v, drv_l, exp_rdy;
  logic [NR*W-1:0] drv_d;
  logic [W-1:0]    exp_data;
  logic            exp_tv, exp_tl, exp_gv;
  logic [1:0]      exp_gid;
  bit              found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      drv_v[i] = (sq_d[i].size() > 0) && !hold[i];
      if (drv_v[i]) begin
        drv_d[i*W +: W] = sq_d[i][0];
        drv_l[i]        = sq_l[i][0];
      end else begin
        drv_d[i*W +: W] = '0;
        drv_l[i]        = 1'b0;
      end
    end
    req_valid     = drv_v;
    req_data      = drv_d;
    req_last      = drv_l;
    rst           = rst_ctl;
    tx_data_ready = rdy_ctl;
    #1;
    cyc++;
    if (cmp_en) begin
      exp_rdy  = '0;
      exp_data = '0;
      exp_tv   = 1'b0;
      exp_tl   = 1'b0;
      exp_gv   = 1'b0;
      exp_gid  = 2'(m_gid);
      if (m_owner >= 0) begin
        exp_rdy[m_owner] = rdy_ctl;
        exp_data = drv_d[m_owner*W +: W];
        exp_tv   = drv_v[m_owner];
        exp_tl   = drv_l[m_owner];
        exp_gv   = 1'b1;
        exp_gid  = 2'(m_owner);
      end
      check($sformatf("cycle%0d_outputs", cyc),
            {15'b0, req_ready, tx_data, tx_data_valid, tx_data_last, grant_valid, grant_id},
            {15'b0, exp_rdy, exp_data, exp_tv, exp_tl, exp_gv, exp_gid});
    end
    if (rst_ctl) begin
      m_owner = -1; m_ptr = 0; m_gid = 0; m_gap = 0;
    end else if (m_owner >= 0) begin
      if (drv_v[m_owner] && rdy_ctl) begin
        log_q.push_back('{m_owner, int'(drv_d[m_owner*W +: W]), drv_l[m_owner], cyc});
        void'(sq_d[m_owner].pop_front());
        void'(sq_l[m_owner].pop_front());
        if (drv_l[m_owner]) begin
          m_ptr   = (m_owner + 1) % NR;
          m_owner = -1;
          m_gap   = GAPC;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      found = 1'b0;
      for (int k = 0; k < NR; k++) begin
        if (!found && drv_v[(m_ptr + k) % NR]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % NR;
          m_gid   = m_owner;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int r, input logic [W-1:0] d, input bit l);
    sq_d[r].push_back(d);
    sq_l[r].push_back(l);
  endtask

  task automatic wait_idle();
    int t = 0;
    bit busy = 1'b1;
    while (busy && t < 500) begin
      busy = (m_owner >= 0) || (m_gap > 0);
      for (int i = 0; i < NR; i++) if (sq_d[i].size() > 0) busy = 1'b1;
      if (busy) begin
        step(1);
        t++;
      end
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy after %0d clocks, expected idle", t);
    end
    step(2);
  endtask

  task automatic chk_log(input string name, input int idx, input int id, input int data, input bit last);
    if (idx >= log_q.size()) begin
      check({name, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    end else begin
      check({name, "_id"}, 32'(log_q[idx].id), 32'(id));
      check({name, "_data"}, 32'(log_q[idx].data), 32'(data));
      check({name, "_last"}, 32'(log_q[idx].last), 32'(last));
    end
  endtask

  int base;
  int eid [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  int edt [10] = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h05, 8'h06};

  initial begin
    for (int i = 0; i < NR; i++) hold[i] = 1'b0;
    step(3);
    cmp_en = 1'b1;
    check("rst_tx_valid", 32'(tx_data_valid), 0);
    check("rst_grant_valid", 32'(grant_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_grant_id", 32'(grant_id), 0);

    // Single requester, three words
    rst_ctl = 1'b0;
    base = log_q.size();
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    check("a_pre_grant", 32'(grant_valid), 0);
    step(1);
    check("a_lat_grant", 32'(grant_valid), 1);
    check("a_lat_data", 32'(tx_data), 32'h41);
    check("a_lat_valid", 32'(tx_data_valid), 1);
    wait_idle();
    chk_log("a_w0", base + 0, 0, 8'h41, 1'b0);
    chk_log("a_w1", base + 1, 0, 8'h42, 1'b0);
    chk_log("a_w2", base + 2, 0, 8'h43, 1'b1);

    // All four requesters with 2-word packets after a reset: 0,1,2,3,0
    rst_ctl = 1'b1; step(1); rst_ctl = 1'b0;
    base = log_q.size();
    for (int r = 0; r < NR; r++) begin
      push(r, 8'(r*16 + 1), 1'b0);
      push(r, 8'(r*16 + 2), 1'b1);
    end
    push(0, 8'h05, 1'b0); push(0, 8'h06, 1'b1);
    wait_idle();
    for (int k = 0; k < 10; k++)
      chk_log($sformatf("b_w%0d", k), base + k, eid[k], edt[k], k[0]);
    if (log_q.size() >= base + 3) begin
      check("b_intra_spacing", 32'(log_q[base+1].cyc - log_q[base].cyc), 1);
      check("b_inter_spacing", 32'(log_q[base+2].cyc - log_q[base+1].cyc), 32'(2 + GAPC));
    end

    // Owner 2 stalls mid-packet while requester 1 waits
    base = log_q.size();
    push(2, 8'hA0, 1'b0); push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b1);
    step(2);
    hold[2] = 1'b1;
    push(1, 8'hB0, 1'b1);
    step(10);
    check("c_hold_gid", 32'(grant_id), 2);
    check("c_hold_gv", 32'(grant_valid), 1);
    check("c_hold_rdy1", 32'(req_ready[1]), 0);
    hold[2] = 1'b0;
    wait_idle();
    chk_log("c_w0", base + 0, 2, 8'hA0, 1'b0);
    chk_log("c_w1", base + 1, 2, 8'hA1, 1'b0);
    chk_log("c_w2", base + 2, 2, 8'hA2, 1'b1);
    chk_log("c_w3", base + 3, 1, 8'hB0, 1'b1);

    // Downstream back-pressure for 5 clocks
    base = log_q.size();
    rdy_ctl = 1'b0;
    push(1, 8'hC0, 1'b0); push(1, 8'hC1, 1'b1);
    step(3);
    check("d_stall_data", 32'(tx_data), 32'hC0);
    check("d_stall_valid", 32'(tx_data_valid), 1);
    check("d_stall_ready", 32'(req_ready), 0);
    step(2);
    rdy_ctl = 1'b1;
    wait_idle();
    check("d_count", 32'(log_q.size() - base), 2);
    chk_log("d_w0", base + 0, 1, 8'hC0, 1'b0);
    chk_log("d_w1", base + 1, 1, 8'hC1, 1'b1);

    // Reset during word 2 of a 4-word packet from requester 3
    base = log_q.size();
    push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b0); push(3, 8'hD2, 1'b0); push(3, 8'hD3, 1'b1);
    step(2);
    rst_ctl = 1'b1;
    sq_d[3].delete();
    sq_l[3].delete();
    step(1);
    check("e_rst_valid", 32'(tx_data_valid), 0);
    check("e_rst_gv", 32'(grant_valid), 0);
    check("e_rst_ready", 32'(req_ready), 0);
    check("e_rst_data", 32'(tx_data), 0);
    check("e_rst_gid", 32'(grant_id), 0);
    rst_ctl = 1'b0;
    push(0, 8'hE0, 1'b1);
    push(3, 8'hF0, 1'b1);
    wait_idle();
    check("e_count", 32'(log_q.size() - base), 3);
    chk_log("e_w0", base + 0, 3, 8'hD0, 1'b0);
    chk_log("e_w1", base + 1, 0, 8'hE0, 1'b1);
    chk_log("e_w2", base + 2, 3, 8'hF0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
